// File: rtl/rv32i_pkg.sv
// rv32i_pkg
// Types and constants shared by the generic memory and its response buffer.
//   mem_rsp_t         : one response entry {rdata, err}. rdata is sized for
//                       the widest legal word (64 bits); narrower memories
//                       zero-extend into it.
//   MEM_RSP_DEPTH_DEF : default number of response FIFO entries.
//   mem_rsp_pack      : builds a response entry from a word and error flag.
package rv32i_pkg;

  localparam int MEM_RSP_DEPTH_DEF = 2;
  localparam int MEM_RSP_DATA_W    = 64;

  typedef struct packed {
    logic [MEM_RSP_DATA_W-1:0] rdata;
    logic                      err;
  } mem_rsp_t;

  function automatic mem_rsp_t mem_rsp_pack(input logic [MEM_RSP_DATA_W-1:0] rdata,
                                            input logic                      err);
    mem_rsp_t r;
    r.rdata = rdata;
    r.err   = err;
    return r;
  endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// mem_rsp_fifo
// Synchronous FIFO holding read responses until the consumer takes them.
// Parameters:
//   WIDTH : entry width in bits
//   DEPTH : number of entries, power of two >= 2
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset; empties the FIFO
//   push      : write push_data at the tail (ignored when full)
//   push_data : entry to enqueue
//   pop       : drop the head entry (ignored when empty)
//   pop_data  : current head entry, valid while count != 0
//   count     : number of entries currently held
module mem_rsp_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly at DEPTH-1 rather than relying on overflow.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push  = push && (count < CNT_W'(DEPTH));
  assign do_pop   = pop && (count != '0);
  assign pop_data = slots[rd_ptr];

  // Pointer and occupancy bookkeeping; a simultaneous push and pop
  // leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; stale slots are never visible
  // because the head is only meaningful while count != 0.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/generic_memory_v2.sv
// generic_memory_v2
// Single-port word-addressed memory with byte strobes, a valid/ready
// request channel and a buffered valid/ready response channel. Reads
// respond one cycle after acceptance; writes produce no response.
// Out-of-range writes are dropped and out-of-range reads answer 0 with
// rsp_err set.
// Parameters:
//   DEPTH     : number of words (>= 2, any value)
//   DATA_W    : word width, 32 or 64
//   RSP_DEPTH : response FIFO entries, power of two >= 2
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   req_valid / req_ready : request handshake
//   req_we, req_addr      : write enable and word address
//   req_wdata, req_be     : write data and byte strobes
//   rsp_valid / rsp_ready : response handshake
//   rsp_rdata, rsp_err    : read data and out-of-range flag
// Optional feature, macro GENERIC_MEMORY_PRELOAD_EN:
//   preload_en, preload_addr, preload_data : full-word backdoor writes,
//   active even during reset; request acceptance is blocked meanwhile.
module generic_memory_v2
  import rv32i_pkg::*;
#(
  parameter  int DEPTH     = 1024,
  parameter  int DATA_W    = 32,
  parameter  int RSP_DEPTH = MEM_RSP_DEPTH_DEF,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int BE_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
`ifdef GENERIC_MEMORY_PRELOAD_EN
  input  logic              preload_en,
  input  logic [ADDR_W-1:0] preload_addr,
  input  logic [DATA_W-1:0] preload_data,
`endif
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int CNT_W = $clog2(RSP_DEPTH+1);
  localparam int RSP_W = $bits(mem_rsp_t);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready_q;
  logic [CNT_W-1:0]  fifo_count;
  logic              req_in_range;
  logic              accept;
  logic              wr_fire;
  logic              rd_fire;
  logic [DATA_W-1:0] rd_word;
  mem_rsp_t          push_rsp;
  logic [RSP_W-1:0]  fifo_head;
  mem_rsp_t          head;
  logic              unused_head_bits;

  // With a power-of-two depth every address is legal, so the range
  // compare is skipped instead of being a constant-true comparison.
  if (DEPTH == (1 << ADDR_W)) begin : g_req_full_range
    assign req_in_range = 1'b1;
  end else begin : g_req_part_range
    localparam logic [ADDR_W:0] RANGE_LIMIT = (ADDR_W+1)'(DEPTH);
    assign req_in_range = ({1'b0, req_addr} < RANGE_LIMIT);
  end

  // ready_q is low on every reset edge and rises on the first edge after
  // reset deasserts, which keeps req_ready low throughout reset.
  always_ff @(posedge clk) begin
    if (reset) ready_q <= 1'b0;
    else       ready_q <= 1'b1;
  end

`ifdef GENERIC_MEMORY_PRELOAD_EN
  assign req_ready = ready_q && (fifo_count < CNT_W'(RSP_DEPTH)) && !preload_en;
`else
  assign req_ready = ready_q && (fifo_count < CNT_W'(RSP_DEPTH));
`endif

  // A request still presented while reset is high is never taken, even
  // when ready_q has not yet been cleared by the first reset edge.
  assign accept  = req_valid && req_ready && !reset;
  assign wr_fire = accept && req_we && req_in_range;
  assign rd_fire = accept && !req_we;

  assign rd_word  = req_in_range ? mem[req_addr] : '0;
  assign push_rsp = mem_rsp_pack(MEM_RSP_DATA_W'(rd_word), !req_in_range);

`ifdef GENERIC_MEMORY_PRELOAD_EN
  logic preload_in_range;

  if (DEPTH == (1 << ADDR_W)) begin : g_pre_full_range
    assign preload_in_range = 1'b1;
  end else begin : g_pre_part_range
    localparam logic [ADDR_W:0] PRE_LIMIT = (ADDR_W+1)'(DEPTH);
    assign preload_in_range = ({1'b0, preload_addr} < PRE_LIMIT);
  end
`endif

  // Storage array, deliberately without reset. Request writes honour the
  // byte strobes; preload writes replace whole words and cannot collide
  // with a request write because preload holds req_ready low.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < BE_W; b++) begin
        if (req_be[b]) mem[req_addr][b*8 +: 8] <= req_wdata[b*8 +: 8];
      end
    end
`ifdef GENERIC_MEMORY_PRELOAD_EN
    if (preload_en && preload_in_range) mem[preload_addr] <= preload_data;
`endif
  end

  mem_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_fire),
    .push_data (push_rsp),
    .pop       (rsp_valid && rsp_ready),
    .pop_data  (fifo_head),
    .count     (fifo_count)
  );

  assign head      = mem_rsp_t'(fifo_head);
  assign rsp_valid = (fifo_count != '0);

  // Outputs are forced to zero when nothing is queued so the bus is clean
  // after reset rather than showing a stale FIFO slot.
  assign rsp_rdata = rsp_valid ? head.rdata[DATA_W-1:0] : '0;
  assign rsp_err   = rsp_valid && head.err;

  // Upper bits of the shared response type are zero for 32-bit words.
  assign unused_head_bits = ^head.rdata;

endmodule

// File: tb/tb_generic_memory_v2.sv
// tb_generic_memory_v2
// Self-checking bench for generic_memory_v2 with DEPTH = 1000 (not a power
// of two), DATA_W = 32, RSP_DEPTH = 2. Covers a directed vector table,
// multi-cycle backpressure/burst/reset sequences and a randomized phase
// compared against a queue-based reference model. The preload sequence is
// only built when GENERIC_MEMORY_PRELOAD_EN is defined.
module tb_generic_memory_v2;

  localparam int DEPTH  = 1000;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int BE_W   = 4;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
`ifdef GENERIC_MEMORY_PRELOAD_EN
  logic              preload_en;
  logic [ADDR_W-1:0] preload_addr;
  logic [DATA_W-1:0] preload_data;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_valid;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic [31:0] model_mem [DEPTH];
  rsp_t        mq[$];

  generic_memory_v2 #(
    .DEPTH     (DEPTH),
    .DATA_W    (DATA_W),
    .RSP_DEPTH (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef GENERIC_MEMORY_PRELOAD_EN
    .preload_en   (preload_en),
    .preload_addr (preload_addr),
    .preload_data (preload_data),
`endif
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_be       (req_be),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic we, input logic [9:0] a,
                               input logic [31:0] d, input logic [3:0] be);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic modelWrite(input int a, input logic [31:0] d, input logic [3:0] be);
    if (a < DEPTH) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) model_mem[a][b*8 +: 8] = d[b*8 +: 8];
      end
    end
  endtask

  // Full-word write of a random value, tracked in the model.
  task automatic initWord(input int a);
    logic [31:0] d;
    d = $urandom;
    applyStimulus(1'b1, 1'b1, 10'(a), d, 4'hF);
    modelWrite(a, d, 4'hF);
    step();
  endtask

  initial begin
    vec_t vecs[14];
    vecs[0]  = '{1'b1, 10'd5,    32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 10'd5,    32'h000000AA, 4'h1, 1'b0, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 10'd5,    32'h0,        4'h0, 1'b1, 32'hDEADBEAA, 1'b0};
    vecs[3]  = '{1'b0, 10'd1000, 32'h0,        4'h0, 1'b1, 32'h00000000, 1'b1};
    vecs[4]  = '{1'b1, 10'd0,    32'h11223344, 4'hF, 1'b0, 32'h0,        1'b0};
    vecs[5]  = '{1'b1, 10'd1000, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 10'd0,    32'h0,        4'h0, 1'b1, 32'h11223344, 1'b0};
    vecs[7]  = '{1'b1, 10'd0,    32'hAABBCCDD, 4'h0, 1'b0, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 10'd0,    32'h0,        4'h0, 1'b1, 32'h11223344, 1'b0};
    vecs[9]  = '{1'b1, 10'd999,  32'hCAFEF00D, 4'hF, 1'b0, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 10'd999,  32'h0,        4'h0, 1'b1, 32'hCAFEF00D, 1'b0};
    vecs[11] = '{1'b1, 10'd999,  32'h12345678, 4'hA, 1'b0, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 10'd999,  32'h0,        4'h0, 1'b1, 32'h12FE560D, 1'b0};
    vecs[13] = '{1'b0, 10'd1023, 32'h0,        4'h0, 1'b1, 32'h00000000, 1'b1};

    reset     = 1'b1;
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
`ifdef GENERIC_MEMORY_PRELOAD_EN
    preload_en   = 1'b0;
    preload_addr = '0;
    preload_data = '0;
`endif

    // Reset state.
    repeat (3) step();
    checkOutput("reset_req_ready", req_ready, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 0);
    checkOutput("reset_rsp_err",   rsp_err,   0);
    reset = 1'b0;
    step();
    checkOutput("ready_after_reset", req_ready, 1);

    // Directed vector table, one request per cycle, responses drained.
    rsp_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      checkOutput($sformatf("vec%0d_req_ready", i), req_ready, 1);
      applyStimulus(1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      if (vecs[i].we) modelWrite(int'(vecs[i].addr), vecs[i].wdata, vecs[i].be);
      step();
      checkOutput($sformatf("vec%0d_rsp_valid", i), rsp_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("vec%0d_rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
        checkOutput($sformatf("vec%0d_rsp_err", i),   rsp_err,   vecs[i].exp_err);
      end
    end
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    step();
    checkOutput("vec_drain_rsp_valid", rsp_valid, 0);

    // Backpressure: two reads fill the FIFO, the third waits.
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 10'd5, '0, '0);
    step();
    checkOutput("bp_ready_after_1", req_ready, 1);
    applyStimulus(1'b1, 1'b0, 10'd0, '0, '0);
    step();
    checkOutput("bp_ready_after_2", req_ready, 0);
    checkOutput("bp_head_data",     rsp_rdata, 32'hDEADBEAA);
    applyStimulus(1'b1, 1'b0, 10'd999, '0, '0);
    step();
    checkOutput("bp_ready_held",  req_ready, 0);
    checkOutput("bp_valid_held",  rsp_valid, 1);
    checkOutput("bp_data_stable", rsp_rdata, 32'hDEADBEAA);
    rsp_ready = 1'b1;
    step();
    checkOutput("bp_second_rsp",   rsp_rdata, 32'h11223344);
    checkOutput("bp_ready_reopen", req_ready, 1);
    step();
    checkOutput("bp_third_rsp", rsp_rdata, 32'h12FE560D);
    checkOutput("bp_third_err", rsp_err,   0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    step();
    checkOutput("bp_drain_valid", rsp_valid, 0);

    // Back-to-back burst of 16 reads.
    for (int a = 0; a < 16; a++) initWord(a);
    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b1, 1'b0, 10'(a), '0, '0);
      step();
      checkOutput($sformatf("burst%0d_ready", a), req_ready, 1);
      checkOutput($sformatf("burst%0d_valid", a), rsp_valid, 1);
      checkOutput($sformatf("burst%0d_data", a),  rsp_rdata, model_mem[a]);
    end
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    step();
    checkOutput("burst_drain_valid", rsp_valid, 0);

    // Reset with two responses pending; a read held across reset is not taken.
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 10'd1, '0, '0);
    step();
    applyStimulus(1'b1, 1'b0, 10'd2, '0, '0);
    step();
    checkOutput("rst_pending_valid", rsp_valid, 1);
    checkOutput("rst_pending_ready", req_ready, 0);
    applyStimulus(1'b1, 1'b0, 10'd3, '0, '0);
    reset = 1'b1;
    step();
    checkOutput("rst_mid_valid", rsp_valid, 0);
    checkOutput("rst_mid_ready", req_ready, 0);
    checkOutput("rst_mid_rdata", rsp_rdata, 0);
    reset = 1'b0;
    step();
    checkOutput("rst_exit_ready", req_ready, 1);
    checkOutput("rst_exit_valid", rsp_valid, 0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    rsp_ready = 1'b1;
    step();
    checkOutput("rst_no_stale", rsp_valid, 0);

    // Randomized traffic against the reference model.
    rsp_ready = 1'b1;
    for (int a = 0; a < 16; a++) initWord(a);
    initWord(999);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    step();
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      logic [9:0] a;
      int         sel;
      logic       acc;
      logic       popd;
      rsp_t       r;
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 10'($urandom_range(0, 15));
      else if (sel == 7) a = 10'd999;
      else               a = 10'($urandom_range(1000, 1023));
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a,
                    $urandom, 4'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);

      checkOutput("rnd_req_ready", req_ready, (mq.size() < 2));
      checkOutput("rnd_rsp_valid", rsp_valid, (mq.size() > 0));
      if (mq.size() > 0) begin
        checkOutput("rnd_rsp_rdata", rsp_rdata, mq[0].data);
        checkOutput("rnd_rsp_err",   rsp_err,   mq[0].err);
      end

      acc  = req_valid && (mq.size() < 2);
      popd = (mq.size() > 0) && rsp_ready;
      if (popd) void'(mq.pop_front());
      if (acc && !req_we) begin
        r.err  = (int'(a) >= DEPTH);
        r.data = r.err ? 32'h0 : model_mem[a];
        mq.push_back(r);
      end
      if (acc && req_we) modelWrite(int'(a), req_wdata, req_be);
      step();
    end
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    rsp_ready = 1'b1;
    repeat (3) step();
    checkOutput("rnd_drain_valid", rsp_valid, 0);

`ifdef GENERIC_MEMORY_PRELOAD_EN
    // Preload blocks requests while active and lands full words.
    preload_en   = 1'b1;
    preload_addr = 10'd3;
    preload_data = 32'h12345678;
    applyStimulus(1'b1, 1'b0, 10'd3, '0, '0);
    #1;
    checkOutput("pre_ready_0", req_ready, 0);
    step();
    checkOutput("pre_ready_1", req_ready, 0);
    checkOutput("pre_valid_1", rsp_valid, 0);
    step();
    checkOutput("pre_ready_2", req_ready, 0);
    preload_en = 1'b0;
    #1;
    checkOutput("pre_ready_release", req_ready, 1);
    step();
    checkOutput("pre_read_valid", rsp_valid, 1);
    checkOutput("pre_read_data",  rsp_rdata, 32'h12345678);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/generic_memory_v2.md
GENERIC_MEMORY_V2 -- requirements
Module: generic_memory_v2

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of words; any value >= 2, not necessarily a power of two.
REQ-002 SHALL have parameter DATA_W, default 32, word width; legal values 32 or 64.
REQ-003 SHALL have parameter RSP_DEPTH, default 2, response FIFO entries; power of two >= 2.
REQ-004 SHALL derive localparams ADDR_W = $clog2(DEPTH) and BE_W = DATA_W/8.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have ports req_valid (input, 1) and req_ready (output, 1), the request handshake.
REQ-008 SHALL have ports req_we (input, 1), req_addr (input, ADDR_W, word address), req_wdata (input, DATA_W) and req_be (input, BE_W, byte strobes).
REQ-009 SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1), the response handshake.
REQ-010 SHALL have ports rsp_rdata (output, DATA_W) and rsp_err (output, 1, out-of-range flag).

Function
REQ-011 SHALL accept a request on a rising edge where req_valid and req_ready are both 1.
REQ-012 SHALL drive req_ready = (fifo_count < RSP_DEPTH) and no preload active, as a function of registered state only, with no path from rsp_ready.
REQ-013 SHALL, on an accepted write, update only the bytes whose req_be bit is 1 at that edge and produce no response.
REQ-014 SHALL, on an accepted read, read the array at that edge and push {data, err} into the FIFO, so rsp_valid = 1 in the next cycle when the FIFO was empty (latency 1).
REQ-015 SHALL pop the FIFO head on an edge where rsp_valid and rsp_ready are both 1; a push and a pop on the same edge leave the count unchanged.
REQ-016 SHALL sustain one read per cycle while rsp_ready is held at 1.
REQ-017 SHALL hold rsp_rdata and rsp_err stable while rsp_valid = 1 and rsp_ready = 0.
REQ-018 SHALL ignore writes with req_addr >= DEPTH.
REQ-019 SHALL answer reads with req_addr >= DEPTH with rdata = 0 and rsp_err = 1; in-range reads SHALL return rsp_err = 0.
REQ-020 SHALL accept a write with req_be = 0 as a no-op.
REQ-021 SHALL make a read accepted in the cycle after a write to the same address return the new data.
REQ-022 SHALL wrap the FIFO read and write pointers modulo RSP_DEPTH.

Reset
REQ-023 SHALL, while reset = 1 on an edge, clear the FIFO pointers and count, making rsp_valid = 0, rsp_err = 0, rsp_rdata = 0 and req_ready = 0 during reset.
REQ-024 SHALL leave array contents undefined by reset (no array clear).
REQ-025 SHALL discard responses still in the FIFO when reset is asserted mid-operation; a request presented in the reset cycle SHALL NOT be accepted.
REQ-026 SHALL raise req_ready in the first cycle after reset deasserts.

Configuration
REQ-027 SHALL, with macro GENERIC_MEMORY_PRELOAD_EN defined, add inputs preload_en (1), preload_addr (ADDR_W) and preload_data (DATA_W).
REQ-028 With GENERIC_MEMORY_PRELOAD_EN defined, SHALL write full words on every edge where preload_en = 1 and the address is in range; this applies also during reset.
REQ-029 With GENERIC_MEMORY_PRELOAD_EN defined, SHALL force req_ready = 0 while preload_en = 1, so preload and request writes never collide.
REQ-030 Without GENERIC_MEMORY_PRELOAD_EN, SHALL NOT have the preload ports and SHALL have no preload logic.

Structure
REQ-031 SHALL place typedef mem_rsp_t {rdata, err} and constant MEM_RSP_DEPTH_DEF = 2 in rv32i_pkg.
REQ-032 SHALL implement the response buffer as sub-module mem_rsp_fifo (synchronous, parametrised width and depth, count output).
REQ-033 SHALL keep the array and byte-strobe logic in generic_memory_v2.

Verification
REQ-034 Write addr 5 data 0xDEADBEEF be 0xF, then write addr 5 data 0x000000AA be 0x1, then read addr 5 -> rdata 0xDEADBEAA, err 0, one cycle after acceptance.
REQ-035 Hold rsp_ready = 0 and issue 3 reads -> two accepted, req_ready = 0 after the second; raise rsp_ready -> responses return in order and the third read is then accepted.
REQ-036 Run 16 back-to-back reads with rsp_ready = 1 -> 16 responses on 16 consecutive cycles, req_ready never drops.
REQ-037 With DEPTH = 1000, read addr 1000 -> rdata 0, err 1; write addr 1000 then read addr 0 -> addr 0 unchanged.
REQ-038 Assert reset with 2 responses pending -> rsp_valid = 0 next cycle, no stale response after deassert.
REQ-039 With GENERIC_MEMORY_PRELOAD_EN defined, preload addr 3 = 0x12345678 while req_valid = 1 -> req_ready = 0 throughout; a later read of addr 3 -> 0x12345678.
